// File: rtl/label_stat.sv
// Connected-component statistics: scans a 32x32 label SRAM, tallies per-label pixel
// count (and bounding box when LABEL_STAT_BBOX_EN is defined), then reports in first-seen order.
module label_stat #(
  parameter int MAX_OBJ = 8,
  parameter int IMG_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [9:0]  sram_a,
  input  logic [7:0]  sram_q,
  output logic        sram_wen,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  out_label,
  output logic [10:0] out_count,
  output logic [4:0]  out_rmin,
  output logic [4:0]  out_rmax,
  output logic [4:0]  out_cmin,
  output logic [4:0]  out_cmax,
  output logic        overflow,
  output logic        done
);
  localparam int NW = $clog2(MAX_OBJ + 1);
  localparam logic [9:0] LAST_A = 10'(IMG_W * IMG_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_EMIT, S_DONE} state_t;
  state_t state;

  logic          pix_vld;
  logic [NW-1:0] n_obj, n_obj_n, emit_idx;
  logic [7:0]    lbl   [MAX_OBJ];
  logic [7:0]    lbl_n [MAX_OBJ];
  logic [10:0]   cnt   [MAX_OBJ];
  logic [10:0]   cnt_n [MAX_OBJ];
  logic          ovf_n;
  logic [MAX_OBJ-1:0] hit;
  logic [7:0]    sel_lbl;
  logic [10:0]   sel_cnt;
`ifdef LABEL_STAT_BBOX_EN
  logic [9:0] addr_d;
  logic [4:0] pix_r, pix_c;
  logic [4:0] rmin [MAX_OBJ], rmax [MAX_OBJ], cmin [MAX_OBJ], cmax [MAX_OBJ];
  logic [4:0] rmin_n [MAX_OBJ], rmax_n [MAX_OBJ], cmin_n [MAX_OBJ], cmax_n [MAX_OBJ];
  logic [4:0] sel_rmin, sel_rmax, sel_cmin, sel_cmax;
  assign pix_r = addr_d[9:5];
  assign pix_c = addr_d[4:0];
`else
  assign out_rmin = '0;
  assign out_rmax = '0;
  assign out_cmin = '0;
  assign out_cmax = '0;
`endif

  assign sram_wen = 1'b1;

  // Parallel lookup/update of the table for the byte currently returned by the SRAM.
  always_comb begin
    lbl_n   = lbl;
    cnt_n   = cnt;
    n_obj_n = n_obj;
    ovf_n   = overflow;
    hit     = '0;
`ifdef LABEL_STAT_BBOX_EN
    rmin_n = rmin;
    rmax_n = rmax;
    cmin_n = cmin;
    cmax_n = cmax;
`endif
    for (int unsigned i = 0; i < MAX_OBJ; i++)
      hit[i] = (NW'(i) < n_obj) && (lbl[i] == sram_q);
    if (pix_vld && sram_q != 8'd0) begin
      if (hit != '0) begin
        for (int unsigned i = 0; i < MAX_OBJ; i++) begin
          if (hit[i]) begin
            cnt_n[i] = cnt[i] + 11'd1;
`ifdef LABEL_STAT_BBOX_EN
            if (pix_r < rmin[i]) rmin_n[i] = pix_r;
            if (pix_r > rmax[i]) rmax_n[i] = pix_r;
            if (pix_c < cmin[i]) cmin_n[i] = pix_c;
            if (pix_c > cmax[i]) cmax_n[i] = pix_c;
`endif
          end
        end
      end else if (n_obj < NW'(MAX_OBJ)) begin
        for (int unsigned i = 0; i < MAX_OBJ; i++) begin
          if (NW'(i) == n_obj) begin
            lbl_n[i] = sram_q;
            cnt_n[i] = 11'd1;
`ifdef LABEL_STAT_BBOX_EN
            rmin_n[i] = pix_r;
            rmax_n[i] = pix_r;
            cmin_n[i] = pix_c;
            cmax_n[i] = pix_c;
`endif
          end
        end
        n_obj_n = n_obj + NW'(1);
      end else begin
        ovf_n = 1'b1;
      end
    end
  end

  // DRAIN emits entry 0 from the post-update table so the final pixel is included.
  always_comb begin
    sel_lbl = lbl_n[0];
    sel_cnt = cnt_n[0];
`ifdef LABEL_STAT_BBOX_EN
    sel_rmin = rmin_n[0];
    sel_rmax = rmax_n[0];
    sel_cmin = cmin_n[0];
    sel_cmax = cmax_n[0];
`endif
    if (state == S_EMIT) begin
      sel_lbl = '0;
      sel_cnt = '0;
`ifdef LABEL_STAT_BBOX_EN
      sel_rmin = '0;
      sel_rmax = '0;
      sel_cmin = '0;
      sel_cmax = '0;
`endif
      for (int unsigned i = 0; i < MAX_OBJ; i++) begin
        if (NW'(i) == emit_idx) begin
          sel_lbl = lbl[i];
          sel_cnt = cnt[i];
`ifdef LABEL_STAT_BBOX_EN
          sel_rmin = rmin[i];
          sel_rmax = rmax[i];
          sel_cmin = cmin[i];
          sel_cmax = cmax[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      sram_a    <= '0;
      pix_vld   <= 1'b0;
      n_obj     <= '0;
      emit_idx  <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_count <= '0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < MAX_OBJ; i++) begin
        lbl[i] <= '0;
        cnt[i] <= '0;
`ifdef LABEL_STAT_BBOX_EN
        rmin[i] <= '0;
        rmax[i] <= '0;
        cmin[i] <= '0;
        cmax[i] <= '0;
`endif
      end
`ifdef LABEL_STAT_BBOX_EN
      addr_d   <= '0;
      out_rmin <= '0;
      out_rmax <= '0;
      out_cmin <= '0;
      out_cmax <= '0;
`endif
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_count <= '0;
      pix_vld   <= 1'b0;
`ifdef LABEL_STAT_BBOX_EN
      out_rmin <= '0;
      out_rmax <= '0;
      out_cmin <= '0;
      out_cmax <= '0;
`endif
      if (state == S_SCAN || state == S_DRAIN) begin
        lbl      <= lbl_n;
        cnt      <= cnt_n;
        n_obj    <= n_obj_n;
        overflow <= ovf_n;
`ifdef LABEL_STAT_BBOX_EN
        rmin <= rmin_n;
        rmax <= rmax_n;
        cmin <= cmin_n;
        cmax <= cmax_n;
`endif
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SCAN;
            busy     <= 1'b1;
            sram_a   <= '0;
            n_obj    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < MAX_OBJ; i++) begin
              lbl[i] <= '0;
              cnt[i] <= '0;
`ifdef LABEL_STAT_BBOX_EN
              rmin[i] <= '0;
              rmax[i] <= '0;
              cmin[i] <= '0;
              cmax[i] <= '0;
`endif
            end
          end
        end
        S_SCAN: begin
          pix_vld <= 1'b1;
`ifdef LABEL_STAT_BBOX_EN
          addr_d <= sram_a;
`endif
          if (sram_a == LAST_A) begin
            sram_a <= '0;
            state  <= S_DRAIN;
          end else begin
            sram_a <= sram_a + 10'd1;
          end
        end
        S_DRAIN: begin
          if (n_obj_n == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_EMIT;
            out_valid <= 1'b1;
            out_label <= sel_lbl;
            out_count <= sel_cnt;
            emit_idx  <= NW'(1);
`ifdef LABEL_STAT_BBOX_EN
            out_rmin <= sel_rmin;
            out_rmax <= sel_rmax;
            out_cmin <= sel_cmin;
            out_cmax <= sel_cmax;
`endif
          end
        end
        S_EMIT: begin
          if (emit_idx == n_obj) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
            out_label <= sel_lbl;
            out_count <= sel_cnt;
            emit_idx  <= emit_idx + NW'(1);
`ifdef LABEL_STAT_BBOX_EN
            out_rmin <= sel_rmin;
            out_rmax <= sel_rmax;
            out_cmin <= sel_cmin;
            out_cmax <= sel_cmax;
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_label_stat.sv
// Bench for label_stat: directed vector table, random images against a raster-order
// reference model, reset-abort and double-start sequences.
module tb_label_stat;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [9:0]  sram_a;
  logic [7:0]  sram_q = '0;
  logic        sram_wen, busy, out_valid, overflow, done;
  logic [7:0]  out_label;
  logic [10:0] out_count;
  logic [4:0]  out_rmin, out_rmax, out_cmin, out_cmax;
  logic [7:0]  mem [1024];

  int cyc = 0, checks = 0, failures = 0;
  int done_off, junk;
  bit exp_ovf, got_ovf;

  typedef struct {int lbl; int cnt; int rmin; int rmax; int cmin; int cmax; int off;} rec_t;
  rec_t exp_q[$], got_q[$];

  typedef struct {int kind; int n; int ovf; int lbl0; int cnt0;
                  int rmin0; int rmax0; int cmin0; int cmax0; int done_at;} vec_t;

`ifdef LABEL_STAT_BBOX_EN
  localparam bit BBOX = 1'b1;
`else
  localparam bit BBOX = 1'b0;
`endif

  label_stat #(.MAX_OBJ(8), .IMG_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sram_a(sram_a), .sram_q(sram_q),
    .sram_wen(sram_wen), .busy(busy), .out_valid(out_valid), .out_label(out_label),
    .out_count(out_count), .out_rmin(out_rmin), .out_rmax(out_rmax), .out_cmin(out_cmin),
    .out_cmax(out_cmax), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sram_q <= mem[sram_a];
  end

  function automatic int bb(input int v);
    return BBOX ? v : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    case (kind)
      1: mem[33] = 8'h05;
      2: begin
        for (int r = 2; r <= 4; r++)
          for (int c = 10; c <= 12; c++) mem[r*32+c] = 8'h03;
        for (int c = 0; c < 32; c++) mem[31*32+c] = 8'h07;
      end
      3: for (int a = 0; a < 9; a++) mem[a] = 8'(a + 1);
      4: for (int a = 0; a < 1024; a++)
           if ($urandom_range(0, 15) == 0) mem[a] = 8'($urandom_range(1, 12));
      5: for (int a = 0; a < 1024; a++)
           if ($urandom_range(0, 2) == 0) mem[a] = 8'($urandom_range(1, 6));
      default: ;
    endcase
  endtask

  // First-seen table built straight from the image in raster order.
  task automatic build_model();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      int v, r, c, found;
      v = int'(mem[a]);
      r = a / 32;
      c = a % 32;
      found = -1;
      if (v == 0) continue;
      foreach (exp_q[k]) if (exp_q[k].lbl == v) found = k;
      if (found >= 0) begin
        exp_q[found].cnt++;
        if (r < exp_q[found].rmin) exp_q[found].rmin = r;
        if (r > exp_q[found].rmax) exp_q[found].rmax = r;
        if (c < exp_q[found].cmin) exp_q[found].cmin = c;
        if (c > exp_q[found].cmax) exp_q[found].cmax = c;
      end else if (exp_q.size() < 8) begin
        exp_q.push_back('{v, 1, r, r, c, c, 0});
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // Offsets count from the start-sampling edge T: offset 1 is the cycle after it.
  task automatic run_scan(input bit dbl);
    int t0, off;
    got_q.delete();
    done_off = -1;
    junk = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 1200; k++) begin
      off = cyc - t0 + 1;
      if (off == 1) begin
        chk("sram_a_first", int'(sram_a), 0);
        chk("busy_after_start", int'(busy), 1);
      end
      if (off == 1024) chk("sram_a_last", int'(sram_a), 1023);
      if (off == 1025) chk("sram_a_drain", int'(sram_a), 0);
      if (sram_wen !== 1'b1) junk++;
      if (!out_valid && (out_label != 0 || out_count != 0 || out_rmin != 0 ||
                         out_rmax != 0 || out_cmin != 0 || out_cmax != 0)) junk++;
      if (!BBOX && (out_rmin != 0 || out_rmax != 0 || out_cmin != 0 || out_cmax != 0)) junk++;
      if (dbl && off == 10) start = 1'b1;
      if (dbl && off == 11) start = 1'b0;
      if (out_valid)
        got_q.push_back('{int'(out_label), int'(out_count), int'(out_rmin), int'(out_rmax),
                          int'(out_cmin), int'(out_cmax), off});
      if (done) begin
        done_off = off;
        got_ovf  = overflow;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_n_obj"}, got_q.size(), exp_q.size());
    chk({tag, "_overflow"}, int'(got_ovf), int'(exp_ovf));
    chk({tag, "_done_at"}, done_off, 1026 + exp_q.size());
    chk({tag, "_idle_outputs"}, junk, 0);
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk({tag, "_label"}, got_q[k].lbl, exp_q[k].lbl);
      chk({tag, "_count"}, got_q[k].cnt, exp_q[k].cnt);
      chk({tag, "_rmin"}, got_q[k].rmin, bb(exp_q[k].rmin));
      chk({tag, "_rmax"}, got_q[k].rmax, bb(exp_q[k].rmax));
      chk({tag, "_cmin"}, got_q[k].cmin, bb(exp_q[k].cmin));
      chk({tag, "_cmax"}, got_q[k].cmax, bb(exp_q[k].cmax));
      chk({tag, "_valid_at"}, got_q[k].off, 1026 + k);
    end
  endtask

  initial begin
    vec_t vt[4];
    int dcount;
    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1026};
    vt[1] = '{1, 1, 0, 5, 1, 1, 1, 1, 1, 1027};
    vt[2] = '{2, 2, 0, 3, 9, 2, 4, 10, 12, 1028};
    vt[3] = '{3, 8, 1, 1, 1, 0, 0, 0, 0, 1034};

    fill(0);
    #1;
    chk("rst_sram_a", int'(sram_a), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_sram_wen", int'(sram_wen), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      fill(vt[i].kind);
      build_model();
      run_scan(1'b0);
      compare_run($sformatf("vec%0d", i));
      chk("vec_n", got_q.size(), vt[i].n);
      chk("vec_ovf", int'(got_ovf), vt[i].ovf);
      chk("vec_done_at", done_off, vt[i].done_at);
      if (vt[i].n > 0 && got_q.size() > 0) begin
        chk("vec_lbl0", got_q[0].lbl, vt[i].lbl0);
        chk("vec_cnt0", got_q[0].cnt, vt[i].cnt0);
        chk("vec_rmin0", got_q[0].rmin, bb(vt[i].rmin0));
        chk("vec_rmax0", got_q[0].rmax, bb(vt[i].rmax0));
        chk("vec_cmin0", got_q[0].cmin, bb(vt[i].cmin0));
        chk("vec_cmax0", got_q[0].cmax, bb(vt[i].cmax0));
      end
      if (vt[i].kind == 2 && got_q.size() > 1) begin
        chk("row31_lbl", got_q[1].lbl, 7);
        chk("row31_cnt", got_q[1].cnt, 32);
        chk("row31_rmin", got_q[1].rmin, bb(31));
        chk("row31_cmax", got_q[1].cmax, bb(31));
      end
    end

    for (int i = 0; i < 4; i++) begin
      fill((i % 2 == 0) ? 4 : 5);
      build_model();
      run_scan(1'b0);
      compare_run($sformatf("rand%0d", i));
    end

    // Second start mid-scan must be ignored.
    fill(2);
    build_model();
    run_scan(1'b1);
    compare_run("double_start");

    // Reset while sram_a == 500: everything clears at once, no done, then a clean rerun.
    fill(2);
    build_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (sram_a == 10'd500) break;
      @(negedge clk);
    end
    chk("abort_reach_500", int'(sram_a), 500);
    reset = 1'b1;
    #1;
    chk("abort_sram_a", int'(sram_a), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_count", int'(out_count), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_sram_wen", int'(sram_wen), 1);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (done || out_valid || busy) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_scan(1'b0);
    compare_run("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
